// File: rtl/mxrv_if_id_pkg.sv
// Shared word-width and constant definitions for the mxrv pipeline registers.
package mxrv_if_id_pkg;

    localparam int unsigned PORT_WORD_WIDTH = 32;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

endpackage

// File: rtl/mxrv_pipe_buf.sv
// Generic 2-entry valid/ready elastic buffer with synchronous clear.
// The caller must not push when full or pop when empty; both are masked here as well.
module mxrv_pipe_buf
    import mxrv_if_id_pkg::*;
#(
    parameter int unsigned       WIDTH     = 2 * PORT_WORD_WIDTH,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status flags come from registered state only.
    always_comb begin
        full    = (count == DEPTH[1:0]);
        empty   = (count == 2'd0);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        rdata   = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; clear has priority over any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= RESET_VAL;
            mem[1] <= RESET_VAL;
        end else if (clear) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= RESET_VAL;
            mem[1] <= RESET_VAL;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mxrv_if_id.sv
// IF/ID pipeline register: elastic buffer between fetch and decode with
// decode hold and jump flush. ready_o depends on registered state only.
module mxrv_if_id
    import mxrv_if_id_pkg::*;
#(
    parameter int unsigned      XLEN     = PORT_WORD_WIDTH,
    parameter logic [XLEN-1:0]  NOP_INST = INST_NOP,
    parameter int unsigned      DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o
);

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [2*XLEN-1:0] head;

    // Handshake gating and NOP/zero substitution when no valid entry is presented.
    always_comb begin
        ready_o     = ~full;
        valid_o     = ~empty & ~flush_i;
        push        = inst_valid_i & ready_o & ~flush_i;
        pop         = valid_o & ready_i & ~hold_i;
        inst_o      = valid_o ? head[2*XLEN-1:XLEN] : NOP_INST;
        inst_addr_o = valid_o ? head[XLEN-1:0]      : '0;
    end

    mxrv_pipe_buf #(
        .WIDTH     (2 * XLEN),
        .DEPTH     (DEPTH),
        .RESET_VAL ({NOP_INST, {XLEN{1'b0}}})
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata ({inst_i, inst_addr_i}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mxrv_if_id.sv
// Directed bench for mxrv_if_id: inputs change on the falling edge, outputs
// are checked 1ns later, state advances on the rising edge.
module tb_mxrv_if_id;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        ready_o;
    logic        flush_i;
    logic        hold_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mxrv_if_id #(
        .XLEN     (32),
        .NOP_INST (32'h0000_0013),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc);
        inst_valid_i = iv;
        inst_i       = ins;
        inst_addr_i  = pc;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
        chk({tag, ".inst"},  inst_o, ins);
        chk({tag, ".addr"},  inst_addr_o, pc);
    endtask

    logic [31:0] sb_q[$];
    logic [15:0] pat;
    logic [31:0] exp_pc;

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_out("rst", 1'b0, 32'h13, 32'h0);
        chk("rst.ready", {31'b0, ready_o}, 32'd1);

        // 1. Reset asserted mid-operation clears immediately
        drive(1'b1, 32'hAAAA_0001, 32'h40);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("pre_rst", 1'b1, 32'hAAAA_0001, 32'h40);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h13, 32'h0);
        chk("async_rst.ready", {31'b0, ready_o}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        chk_out("idle", 1'b0, 32'h13, 32'h0);
        chk("idle.ready", {31'b0, ready_o}, 32'd1);

        // 2. Streaming with ready_i=1
        ready_i = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'h0);
        tick();
        drive(1'b1, 32'h0010_0113, 32'h4);
        #1;
        chk_out("stream0", 1'b1, 32'h0050_0093, 32'h0);
        tick();
        drive(1'b1, 32'h0020_81B3, 32'h8);
        #1;
        chk_out("stream1", 1'b1, 32'h0010_0113, 32'h4);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("stream2", 1'b1, 32'h0020_81B3, 32'h8);
        tick();
        #1;
        chk_out("stream_end", 1'b0, 32'h13, 32'h0);

        // 3. Backpressure: two accepts then full, C waits
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'h10);
        #1;
        chk("bp.ready0", {31'b0, ready_o}, 32'd1);
        tick();
        drive(1'b1, 32'hB, 32'h14);
        #1;
        chk("bp.ready1", {31'b0, ready_o}, 32'd1);
        chk_out("bp.headA", 1'b1, 32'hA, 32'h10);
        tick();
        drive(1'b1, 32'hC, 32'h18);
        #1;
        chk("bp.full", {31'b0, ready_o}, 32'd0);
        tick();
        #1;
        chk("bp.still_full", {31'b0, ready_o}, 32'd0);
        chk_out("bp.headA2", 1'b1, 32'hA, 32'h10);
        ready_i = 1'b1;
        tick();
        #1;
        chk("bp.reopen", {31'b0, ready_o}, 32'd1);
        chk_out("bp.headB", 1'b1, 32'hB, 32'h14);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("bp.headC", 1'b1, 32'hC, 32'h18);
        tick();
        #1;
        chk_out("bp.empty", 1'b0, 32'h13, 32'h0);

        // 4. Hold with two entries buffered
        ready_i = 1'b0;
        drive(1'b1, 32'h0000_0A01, 32'h30);
        tick();
        drive(1'b1, 32'h0000_0A02, 32'h34);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        hold_i  = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_out("hold", 1'b1, 32'h0000_0A01, 32'h30);
            tick();
        end
        hold_i = 1'b0;
        #1;
        chk_out("hold.rel", 1'b1, 32'h0000_0A01, 32'h30);
        tick();
        #1;
        chk_out("hold.drain", 1'b1, 32'h0000_0A02, 32'h34);
        tick();
        #1;
        chk_out("hold.empty", 1'b0, 32'h13, 32'h0);

        // 5. Flush with two entries buffered and a push in the flush cycle
        ready_i = 1'b0;
        drive(1'b1, 32'h0000_0B01, 32'h50);
        tick();
        drive(1'b1, 32'h0000_0B02, 32'h54);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 32'h20);
        flush_i = 1'b1;
        ready_i = 1'b1;
        hold_i  = 1'b1;
        #1;
        chk_out("flush.cyc", 1'b0, 32'h13, 32'h0);
        tick();
        flush_i = 1'b0;
        hold_i  = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("flush.after", 1'b0, 32'h13, 32'h0);
        chk("flush.ready", {31'b0, ready_o}, 32'd1);
        drive(1'b1, 32'h0000_0513, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk_out("flush.refill", 1'b1, 32'h0000_0513, 32'h100);
        tick();
        #1;
        chk_out("flush.empty", 1'b0, 32'h13, 32'h0);

        // 6. Toggling inst_valid_i with ready_i=1: scoreboard of PCs
        ready_i = 1'b1;
        pat = 16'b1101_1011_0111_0010;
        for (int k = 0; k < 16; k++) begin
            if (sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                chk_out("sb", 1'b1, exp_pc ^ 32'h1000_0000, exp_pc);
            end else begin
                chk_out("sb.bubble", 1'b0, 32'h13, 32'h0);
            end
            chk("sb.ready", {31'b0, ready_o}, 32'd1);
            drive(pat[k], (32'h200 + 32'(4 * k)) ^ 32'h1000_0000, 32'h200 + 32'(4 * k));
            if (pat[k]) sb_q.push_back(32'h200 + 32'(4 * k));
            tick();
            #1;
        end
        drive(1'b0, 32'h0, 32'h0);
        if (sb_q.size() != 0) begin
            exp_pc = sb_q.pop_front();
            chk_out("sb.last", 1'b1, exp_pc ^ 32'h1000_0000, exp_pc);
        end
        tick();
        #1;
        chk_out("sb.empty", 1'b0, 32'h13, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
